ga_stop_ctrl: RTL and testbench
===============================

# ga_stop_ctrl

Generation-level termination controller for the GA datapath. It sits directly downstream of the best-fitness tracker and samples the tracked `best_fit` / `best` pair at the end of every generation. It counts generations and generations without improvement, and decides when the run stops: target reached, stagnation, or generation limit. On stop it latches the final result and reports the reason. It also issues the one-cycle clear that re-initialises the tracker at the start of each run.

## Interface
- `FIT_WIDTH`, 27, width of fitness values (lower is better)
- `CHROM_WIDTH`, 8, width of a chromosome
- `GEN_WIDTH`, 8, width of the generation counter
- `MAX_GEN`, 200, generation limit; must satisfy 1 ≤ MAX_GEN ≤ 2^GEN_WIDTH−1
- `STALL_GEN`, 16, consecutive non-improving generations that trigger a stop; must be ≥ 1
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `start`  in  1  start-run request pulse
- `gen_done`  in  1  end-of-generation strobe from the generation sequencer
- `best_fit`  in  FIT_WIDTH  tracked best fitness from the tracker
- `best`  in  CHROM_WIDTH  tracked best chromosome from the tracker
- `target_fit`  in  FIT_WIDTH  stop threshold; stop when best_fit ≤ target_fit
- `best_clr`  out  1  one-cycle clear to the tracker's reset
- `busy`  out  1  high while in RUN
- `done`  out  1  high while in DONE
- `stop_reason`  out  2  0 none, 1 target, 2 stall, 3 max-gen
- `gen_count`  out  GEN_WIDTH  generations completed in the current run
- `result_fit`  out  FIT_WIDTH  latched final fitness
- `result_chrom`  out  CHROM_WIDTH  latched final chromosome

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On `start`: clear `gen_count` and the stall counter, set `prev_fit` to all ones, pulse `best_clr`, go to RUN.
  - `gen_done` is ignored.
- **RUN**, on each `gen_done`:
  - `gen_count` ← `gen_count` + 1.
  - If `best_fit` < `prev_fit`: `prev_fit` ← `best_fit` and the stall counter ← 0.
  - Otherwise the stall counter ← stall counter + 1.
- **Stop test (RUN, same cycle, on the updated values), priority order:**
  - target: `best_fit` ≤ `target_fit`
  - stall: new stall count = STALL_GEN
  - max-gen: new `gen_count` = MAX_GEN
- **On stop:**
  - Latch `result_fit` ← `best_fit` and `result_chrom` ← `best`.
  - Set `stop_reason`, go to DONE.
  - `gen_count` keeps its final value.
- `start` in RUN is ignored.
- **DONE**
  - Outputs hold.
  - `start` restarts exactly as from IDLE: counters clear, `best_clr` pulses, `stop_reason` ← 0, go to RUN. `result_*` hold until the next stop.
  - `gen_done` is ignored.
- **Counter widths**
  - Stall counter is $clog2(STALL_GEN+1) bits.
  - Neither counter can exceed its limit, because reaching the limit forces DONE.
- **First-generation boundary:** if `best_fit` is still all ones (nothing evaluated), it is not < `prev_fit`, so the generation counts as a stall.
- **Simultaneous events:** `start` and `gen_done` in the same IDLE/DONE cycle means `start` wins and `gen_done` is dropped.

## Timing
- All outputs are registered.
- **Reset values:** state IDLE, `busy` = 0, `done` = 0, `best_clr` = 0, `stop_reason` = 0, `gen_count` = 0, `result_fit` = 0, `result_chrom` = 0. Internal: `prev_fit` = all ones, stall counter = 0.
- Reset asserted mid-run aborts immediately to the reset values. `best_clr` is not pulsed by reset; the tracker receives system `reset` directly.
- `best_clr` is high for exactly the cycle after `start` is sampled, coincident with `busy` rising.
- **Input sampling:** `best_fit`/`best` are sampled on the `gen_done` edge. The sequencer asserts `gen_done` no earlier than one cycle after the last fitness of the generation is presented to the tracker, since the tracker's output is registered.
- **Stop latency:** `done` and `stop_reason` are valid one cycle after the stopping `gen_done`, and `busy` falls in that same cycle.
- Back-to-back `gen_done` on consecutive cycles is legal; each is counted.

## Test plan
- **Target stop:**
  - Stimulus: `target_fit` = 100, MAX_GEN = 200, STALL_GEN = 16; `best_fit` = 500, 300, 90 at gens 1–3.
  - Required: `done` one cycle after the 3rd `gen_done`, `stop_reason` = 1, `gen_count` = 3, `result_fit` = 90, `result_chrom` = `best` at that edge.
- **Stall stop:**
  - Stimulus: `target_fit` = 0, STALL_GEN = 4; `best_fit` = 50 at gen 1, then held at 50.
  - Required: `stop_reason` = 2 after gen 5, `gen_count` = 5.
- **Max-gen stop:**
  - Stimulus: MAX_GEN = 6, STALL_GEN = 16; `best_fit` strictly decreasing every generation, `target_fit` = 0.
  - Required: `stop_reason` = 3, `gen_count` = 6.
- **Priority:**
  - Stimulus: MAX_GEN = 2, `target_fit` = 10; gen 2 has `best_fit` = 10.
  - Required: `stop_reason` = 1 (not 3).
- **Handshake corners:**
  - Stimulus: `start` and `gen_done` in the same IDLE cycle, `best_fit` = all ones at gen 1, then `start` asserted during RUN.
  - Required: `best_clr` is a single-cycle pulse; `gen_count` = 0 after `start`; gen 1 counts as a stall; the RUN-state `start` is ignored.
- **Reset mid-run and restart:**
  - Stimulus: reset at gen 3; then run to DONE and assert `start`.
  - Required: after reset, every output is at its reset value. On restart, `stop_reason` = 0, `gen_count` = 0, `best_clr` pulses, and `result_*` hold the previous values until the next stop.

Source files
------------

// File: rtl/ga_stop_ctrl.sv
// ga_stop_ctrl
// Generation-level termination controller for the GA datapath. It samples the
// best-fitness tracker's best_fit/best pair on every gen_done strobe, counts
// generations and consecutive non-improving generations, and stops the run on
// target reached, stagnation or generation limit (checked in that priority).
// On stop the final fitness/chromosome are latched and the reason reported.
// It also issues the one-cycle clear that re-initialises the tracker per run.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           start-run request pulse (honoured in IDLE and DONE)
//   gen_done        end-of-generation strobe (honoured in RUN only)
//   best_fit, best  tracked best fitness / chromosome (lower fitness is better)
//   target_fit      stop threshold: stop when best_fit <= target_fit
//   best_clr        one-cycle clear to the tracker, coincident with busy rising
//   busy, done      high while in RUN / DONE
//   stop_reason     0 none, 1 target, 2 stall, 3 max-gen
//   gen_count       generations completed in the current run
//   result_fit      fitness latched at the stopping generation
//   result_chrom    chromosome latched at the stopping generation
module ga_stop_ctrl #(
    parameter int FIT_WIDTH   = 27,
    parameter int CHROM_WIDTH = 8,
    parameter int GEN_WIDTH   = 8,
    parameter int MAX_GEN     = 200,
    parameter int STALL_GEN   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   gen_done,
    input  logic [FIT_WIDTH-1:0]   best_fit,
    input  logic [CHROM_WIDTH-1:0] best,
    input  logic [FIT_WIDTH-1:0]   target_fit,
    output logic                   best_clr,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             stop_reason,
    output logic [GEN_WIDTH-1:0]   gen_count,
    output logic [FIT_WIDTH-1:0]   result_fit,
    output logic [CHROM_WIDTH-1:0] result_chrom
);

    localparam int STALL_W = $clog2(STALL_GEN + 1);
    localparam logic [STALL_W-1:0]   STALL_LIM = STALL_W'(STALL_GEN);
    localparam logic [GEN_WIDTH-1:0] GEN_LIM   = GEN_WIDTH'(MAX_GEN);

    localparam logic [1:0] R_NONE   = 2'd0;
    localparam logic [1:0] R_TARGET = 2'd1;
    localparam logic [1:0] R_STALL  = 2'd2;
    localparam logic [1:0] R_MAXGEN = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [FIT_WIDTH-1:0] prev_fit;
    logic [STALL_W-1:0]   stall_cnt;

    logic                 improved;
    logic [STALL_W-1:0]   stall_nxt;
    logic [GEN_WIDTH-1:0] gen_nxt;
    logic [1:0]           reason_nxt;

    // Updated counters for the generation being closed; the stop test uses
    // these new values so the limit is detected on the generation reaching it.
    // An all-ones best_fit (nothing evaluated yet) never beats the all-ones
    // prev_fit seed, so such a generation counts as a stall.
    always_comb begin
        improved  = best_fit < prev_fit;
        gen_nxt   = gen_count + GEN_WIDTH'(1);
        stall_nxt = improved ? '0 : stall_cnt + STALL_W'(1);
        if (best_fit <= target_fit)
            reason_nxt = R_TARGET;
        else if (stall_nxt == STALL_LIM)
            reason_nxt = R_STALL;
        else if (gen_nxt == GEN_LIM)
            reason_nxt = R_MAXGEN;
        else
            reason_nxt = R_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            best_clr     <= 1'b0;
            stop_reason  <= R_NONE;
            gen_count    <= '0;
            result_fit   <= '0;
            result_chrom <= '0;
            prev_fit     <= '1;
            stall_cnt    <= '0;
        end else begin
            best_clr <= 1'b0;
            case (state)
                // start beats a coincident gen_done; result_* are kept so the
                // previous run's answer stays readable until the next stop.
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        best_clr    <= 1'b1;
                        stop_reason <= R_NONE;
                        gen_count   <= '0;
                        stall_cnt   <= '0;
                        prev_fit    <= '1;
                    end
                end
                RUN: begin
                    if (gen_done) begin
                        gen_count <= gen_nxt;
                        stall_cnt <= stall_nxt;
                        if (improved)
                            prev_fit <= best_fit;
                        if (reason_nxt != R_NONE) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            stop_reason  <= reason_nxt;
                            result_fit   <= best_fit;
                            result_chrom <= best;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_stop_ctrl.sv
// Bench for ga_stop_ctrl. Three instances share the inputs:
//   0: MAX_GEN=200, STALL_GEN=16   1: MAX_GEN=6, STALL_GEN=4   2: MAX_GEN=2, STALL_GEN=4
// A behavioural model pushes an expected stop record per instance whenever
// stimulus should end a run; tests pop and compare once done is up.
module tb_ga_stop_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        gen_done = 1'b0;
    logic [26:0] best_fit = '0;
    logic [7:0]  best = '0;
    logic [26:0] target_fit = '0;

    logic        clr_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [1:0]  reason_v [3];
    logic [7:0]  gen_v [3];
    logic [26:0] rfit_v [3];
    logic [7:0]  rchr_v [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ga_stop_ctrl #(
            .FIT_WIDTH  (27),
            .CHROM_WIDTH(8),
            .GEN_WIDTH  (8),
            .MAX_GEN    (g == 0 ? 200 : (g == 1 ? 6 : 2)),
            .STALL_GEN  (g == 0 ? 16 : 4)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start),
            .gen_done    (gen_done),
            .best_fit    (best_fit),
            .best        (best),
            .target_fit  (target_fit),
            .best_clr    (clr_v[g]),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .stop_reason (reason_v[g]),
            .gen_count   (gen_v[g]),
            .result_fit  (rfit_v[g]),
            .result_chrom(rchr_v[g])
        );
    end

    typedef struct {
        logic [1:0]  reason;
        int          gen;
        logic [26:0] fit;
        logic [7:0]  chrom;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // model state: 0 idle, 1 run, 2 done
    int          m_state [3];
    int          m_gen [3];
    int          m_stall [3];
    logic [26:0] m_prev [3];
    int          m_max [3] = '{200, 6, 2};
    int          m_stl [3] = '{16, 4, 4};

    // Drive one clock worth of inputs, then advance the model for that edge.
    task automatic do_cycle(input bit rs, input bit st, input bit gd,
                            input logic [26:0] f, input logic [7:0] c);
        exp_t e;
        logic [1:0] r;
        reset = rs; start = st; gen_done = gd; best_fit = f; best = c;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; gen_done = 1'b0;
        if (rs) begin
            for (int i = 0; i < 3; i++) m_state[i] = 0;
            q0.delete(); q1.delete(); q2.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_state[i] != 1) begin
                    if (st) begin
                        m_state[i] = 1; m_gen[i] = 0; m_stall[i] = 0; m_prev[i] = '1;
                    end
                end else if (gd) begin
                    m_gen[i]++;
                    if (f < m_prev[i]) begin
                        m_prev[i] = f; m_stall[i] = 0;
                    end else begin
                        m_stall[i]++;
                    end
                    if (f <= target_fit)            r = 2'd1;
                    else if (m_stall[i] == m_stl[i]) r = 2'd2;
                    else if (m_gen[i] == m_max[i])   r = 2'd3;
                    else                             r = 2'd0;
                    if (r != 2'd0) begin
                        e.reason = r; e.gen = m_gen[i]; e.fit = f; e.chrom = c;
                        m_state[i] = 2;
                        case (i)
                            0: q0.push_back(e);
                            1: q1.push_back(e);
                            default: q2.push_back(e);
                        endcase
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_cycle(1, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_v[i], done_v[i], clr_v[i], reason_v[i], gen_v[i], rfit_v[i], rchr_v[i]} !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b clr=%b reason=%0d gen=%0d rfit=%0d rchr=%0d, required all 0",
                         i, busy_v[i], done_v[i], clr_v[i], reason_v[i], gen_v[i], rfit_v[i], rchr_v[i]);
            end
        end
        do_cycle(0, 0, 1, 27'd5, 8'd1);
        checks++;
        if (busy_v[0] !== 1'b0 || gen_v[0] !== 8'd0) begin
            errors++;
            $display("FAIL idle_gen_done: busy=%b gen=%0d, required busy=0 gen=0", busy_v[0], gen_v[0]);
        end
    endtask

    task automatic test_target();
        exp_t e;
        do_cycle(1, 0, 0, '0, '0);
        target_fit = 27'd100;
        do_cycle(0, 1, 0, '0, '0);
        checks++;
        if (clr_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || gen_v[0] !== 8'd0) begin
            errors++;
            $display("FAIL target_start: clr=%b busy=%b gen=%0d, required 1 1 0", clr_v[0], busy_v[0], gen_v[0]);
        end
        do_cycle(0, 0, 1, 27'd500, 8'h10);
        checks++;
        if (clr_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL target_clr_pulse: clr=%b, required 0", clr_v[0]);
        end
        do_cycle(0, 0, 1, 27'd300, 8'h20);
        checks++;
        if (done_v[0] !== 1'b0 || gen_v[0] !== 8'd2) begin
            errors++;
            $display("FAIL target_gen2: done=%b gen=%0d, required done=0 gen=2", done_v[0], gen_v[0]);
        end
        do_cycle(0, 0, 1, 27'd90, 8'hA5);
        checks++;
        if (q0.size() == 0) begin
            errors++;
            $display("FAIL target_scoreboard: no expected stop queued, required one");
        end else begin
            e = q0.pop_front();
            if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || reason_v[0] !== e.reason ||
                gen_v[0] !== 8'(e.gen) || rfit_v[0] !== e.fit || rchr_v[0] !== e.chrom) begin
                errors++;
                $display("FAIL target_stop: done=%b busy=%b reason=%0d gen=%0d rfit=%0d rchr=%h, required 1 0 %0d %0d %0d %h",
                         done_v[0], busy_v[0], reason_v[0], gen_v[0], rfit_v[0], rchr_v[0], e.reason, e.gen, e.fit, e.chrom);
            end
        end
        checks++;
        if (reason_v[0] !== 2'd1 || gen_v[0] !== 8'd3 || rfit_v[0] !== 27'd90 || rchr_v[0] !== 8'hA5) begin
            errors++;
            $display("FAIL target_values: reason=%0d gen=%0d rfit=%0d rchr=%h, required 1 3 90 a5",
                     reason_v[0], gen_v[0], rfit_v[0], rchr_v[0]);
        end
        do_cycle(0, 0, 1, 27'd1, 8'h01);
        checks++;
        if (gen_v[0] !== 8'd3 || rfit_v[0] !== 27'd90 || done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: gen=%0d rfit=%0d done=%b, required 3 90 1", gen_v[0], rfit_v[0], done_v[0]);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        do_cycle(1, 0, 0, '0, '0);
        target_fit = 27'd0;
        do_cycle(0, 1, 0, '0, '0);
        for (int g = 1; g <= 5; g++) begin
            do_cycle(0, 0, 1, 27'd50, 8'(g));
            if (g == 4) begin
                checks++;
                if (done_v[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_early: done=%b after gen 4, required 0", done_v[1]);
                end
            end
        end
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL stall_scoreboard: no expected stop queued, required one");
        end else begin
            e = q1.pop_front();
            if (done_v[1] !== 1'b1 || reason_v[1] !== e.reason || gen_v[1] !== 8'(e.gen) ||
                rfit_v[1] !== e.fit || rchr_v[1] !== e.chrom) begin
                errors++;
                $display("FAIL stall_stop: done=%b reason=%0d gen=%0d rfit=%0d rchr=%h, required 1 %0d %0d %0d %h",
                         done_v[1], reason_v[1], gen_v[1], rfit_v[1], rchr_v[1], e.reason, e.gen, e.fit, e.chrom);
            end
        end
        checks++;
        if (reason_v[1] !== 2'd2 || gen_v[1] !== 8'd5) begin
            errors++;
            $display("FAIL stall_values: reason=%0d gen=%0d, required 2 5", reason_v[1], gen_v[1]);
        end
    endtask

    task automatic test_maxgen();
        exp_t e;
        do_cycle(1, 0, 0, '0, '0);
        target_fit = 27'd0;
        do_cycle(0, 1, 0, '0, '0);
        for (int g = 1; g <= 6; g++) do_cycle(0, 0, 1, 27'(70 - 10 * g), 8'(8'h40 + g));
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL maxgen_scoreboard: no expected stop queued, required one");
        end else begin
            e = q1.pop_front();
            if (done_v[1] !== 1'b1 || reason_v[1] !== e.reason || gen_v[1] !== 8'(e.gen) ||
                rfit_v[1] !== e.fit || rchr_v[1] !== e.chrom) begin
                errors++;
                $display("FAIL maxgen_stop: done=%b reason=%0d gen=%0d rfit=%0d rchr=%h, required 1 %0d %0d %0d %h",
                         done_v[1], reason_v[1], gen_v[1], rfit_v[1], rchr_v[1], e.reason, e.gen, e.fit, e.chrom);
            end
        end
        checks++;
        if (reason_v[1] !== 2'd3 || gen_v[1] !== 8'd6 || rfit_v[1] !== 27'd10) begin
            errors++;
            $display("FAIL maxgen_values: reason=%0d gen=%0d rfit=%0d, required 3 6 10", reason_v[1], gen_v[1], rfit_v[1]);
        end
    endtask

    task automatic test_priority();
        do_cycle(1, 0, 0, '0, '0);
        target_fit = 27'd10;
        do_cycle(0, 1, 0, '0, '0);
        do_cycle(0, 0, 1, 27'd20, 8'h01);
        do_cycle(0, 0, 1, 27'd10, 8'h02);
        checks++;
        if (done_v[2] !== 1'b1 || reason_v[2] !== 2'd1 || gen_v[2] !== 8'd2) begin
            errors++;
            $display("FAIL priority: done=%b reason=%0d gen=%0d, required 1 1 2", done_v[2], reason_v[2], gen_v[2]);
        end
        if (q2.size() != 0) void'(q2.pop_front());
    endtask

    task automatic test_handshake();
        exp_t e;
        do_cycle(1, 0, 0, '0, '0);
        target_fit = 27'd0;
        do_cycle(0, 1, 1, '1, 8'h00);
        checks++;
        if (clr_v[1] !== 1'b1 || busy_v[1] !== 1'b1 || gen_v[1] !== 8'd0) begin
            errors++;
            $display("FAIL hs_start_wins: clr=%b busy=%b gen=%0d, required 1 1 0", clr_v[1], busy_v[1], gen_v[1]);
        end
        do_cycle(0, 0, 1, '1, 8'h01);
        checks++;
        if (clr_v[1] !== 1'b0 || gen_v[1] !== 8'd1) begin
            errors++;
            $display("FAIL hs_gen1: clr=%b gen=%0d, required 0 1", clr_v[1], gen_v[1]);
        end
        do_cycle(0, 1, 0, '0, '0);
        checks++;
        if (clr_v[1] !== 1'b0 || gen_v[1] !== 8'd1 || busy_v[1] !== 1'b1) begin
            errors++;
            $display("FAIL hs_run_start: clr=%b gen=%0d busy=%b, required 0 1 1", clr_v[1], gen_v[1], busy_v[1]);
        end
        for (int g = 2; g <= 4; g++) do_cycle(0, 0, 1, '1, 8'(g));
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL hs_scoreboard: no expected stop queued, required one");
        end else begin
            e = q1.pop_front();
            if (done_v[1] !== 1'b1 || reason_v[1] !== e.reason || gen_v[1] !== 8'(e.gen)) begin
                errors++;
                $display("FAIL hs_stall_stop: done=%b reason=%0d gen=%0d, required 1 %0d %0d",
                         done_v[1], reason_v[1], gen_v[1], e.reason, e.gen);
            end
        end
        checks++;
        if (reason_v[1] !== 2'd2 || gen_v[1] !== 8'd4) begin
            errors++;
            $display("FAIL hs_first_gen_stall: reason=%0d gen=%0d, required 2 4", reason_v[1], gen_v[1]);
        end
    endtask

    task automatic test_reset_restart();
        exp_t e;
        do_cycle(1, 0, 0, '0, '0);
        target_fit = 27'd0;
        do_cycle(0, 1, 0, '0, '0);
        do_cycle(0, 0, 1, 27'd40, 8'h0A);
        do_cycle(0, 0, 1, 27'd30, 8'h0B);
        do_cycle(1, 0, 1, 27'd20, 8'h0C);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_v[i], done_v[i], clr_v[i], reason_v[i], gen_v[i], rfit_v[i], rchr_v[i]} !== '0) begin
                errors++;
                $display("FAIL midrun_reset[%0d]: busy=%b done=%b clr=%b reason=%0d gen=%0d rfit=%0d rchr=%0d, required all 0",
                         i, busy_v[i], done_v[i], clr_v[i], reason_v[i], gen_v[i], rfit_v[i], rchr_v[i]);
            end
        end
        do_cycle(0, 1, 0, '0, '0);
        do_cycle(0, 0, 1, 27'd70, 8'h11);
        do_cycle(0, 0, 1, 27'd60, 8'h3C);
        checks++;
        if (q2.size() == 0) begin
            errors++;
            $display("FAIL restart_scoreboard1: no expected stop queued, required one");
        end else begin
            e = q2.pop_front();
            if (done_v[2] !== 1'b1 || reason_v[2] !== e.reason || gen_v[2] !== 8'(e.gen) ||
                rfit_v[2] !== e.fit || rchr_v[2] !== e.chrom) begin
                errors++;
                $display("FAIL restart_first_stop: done=%b reason=%0d gen=%0d rfit=%0d rchr=%h, required 1 %0d %0d %0d %h",
                         done_v[2], reason_v[2], gen_v[2], rfit_v[2], rchr_v[2], e.reason, e.gen, e.fit, e.chrom);
            end
        end
        do_cycle(0, 1, 0, '0, '0);
        checks++;
        if (reason_v[2] !== 2'd0 || gen_v[2] !== 8'd0 || clr_v[2] !== 1'b1 || busy_v[2] !== 1'b1 ||
            done_v[2] !== 1'b0 || rfit_v[2] !== 27'd60 || rchr_v[2] !== 8'h3C) begin
            errors++;
            $display("FAIL restart_state: reason=%0d gen=%0d clr=%b busy=%b done=%b rfit=%0d rchr=%h, required 0 0 1 1 0 60 3c",
                     reason_v[2], gen_v[2], clr_v[2], busy_v[2], done_v[2], rfit_v[2], rchr_v[2]);
        end
        do_cycle(0, 0, 1, 27'd5, 8'h77);
        checks++;
        if (clr_v[2] !== 1'b0 || gen_v[2] !== 8'd1 || rfit_v[2] !== 27'd60) begin
            errors++;
            $display("FAIL back_to_back_1: clr=%b gen=%0d rfit=%0d, required 0 1 60", clr_v[2], gen_v[2], rfit_v[2]);
        end
        do_cycle(0, 0, 1, 27'd5, 8'h78);
        checks++;
        if (q2.size() == 0) begin
            errors++;
            $display("FAIL restart_scoreboard2: no expected stop queued, required one");
        end else begin
            e = q2.pop_front();
            if (done_v[2] !== 1'b1 || reason_v[2] !== e.reason || gen_v[2] !== 8'(e.gen) ||
                rfit_v[2] !== e.fit || rchr_v[2] !== e.chrom) begin
                errors++;
                $display("FAIL back_to_back_stop: done=%b reason=%0d gen=%0d rfit=%0d rchr=%h, required 1 %0d %0d %0d %h",
                         done_v[2], reason_v[2], gen_v[2], rfit_v[2], rchr_v[2], e.reason, e.gen, e.fit, e.chrom);
            end
        end
        checks++;
        if (reason_v[2] !== 2'd3 || rfit_v[2] !== 27'd5 || rchr_v[2] !== 8'h78) begin
            errors++;
            $display("FAIL back_to_back_values: reason=%0d rfit=%0d rchr=%h, required 3 5 78", reason_v[2], rfit_v[2], rchr_v[2]);
        end
    endtask

    initial begin
        test_reset();
        test_target();
        test_stall();
        test_maxgen();
        test_priority();
        test_handshake();
        test_reset_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
